// File: rtl/add_tc_pkg.sv
`default_nettype none
// ============================================================================
// Package     : add_tc_pkg
// Description : Shared constants and types for the pipelined two's-complement
//               add/sub unit: op codes, signed extremes, stage payloads.
// Revision    : 1.0 - initial release
// ============================================================================
package add_tc_pkg;

    // Default datapath width; must be a multiple of 4 (one lookahead slice per nibble)
    localparam int ADD_TC_WIDTH = 16;

    // Op codes carried on in_op
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Signed extremes used as saturation targets
    localparam logic [ADD_TC_WIDTH-1:0] S_MIN = {1'b1, {(ADD_TC_WIDTH-1){1'b0}}};
    localparam logic [ADD_TC_WIDTH-1:0] S_MAX = {1'b0, {(ADD_TC_WIDTH-1){1'b1}}};

    // Stage-1 payload: operand A and the already-conditioned B / carry-in
    typedef struct packed {
        logic [ADD_TC_WIDTH-1:0] a;
        logic [ADD_TC_WIDTH-1:0] b_eff;
        logic                    c_in;
    } s1_ops_t;

    // Stage-2 payload: final result and its status flags
    typedef struct packed {
        logic [ADD_TC_WIDTH-1:0] sum;
        logic                    cout;
        logic                    ovf;
        logic                    zero;
        logic                    neg;
    } res_t;

    // Saturation target selected by the sign of operand A on overflow
    function automatic logic [ADD_TC_WIDTH-1:0] sat_value(input logic a_msb);
        return a_msb ? S_MIN : S_MAX;
    endfunction

endpackage : add_tc_pkg
`default_nettype wire

// File: rtl/add_tc16_core.sv
`default_nettype none
// ============================================================================
// Module      : add_tc16_core
// Description : Combinational WIDTH-bit carry-lookahead adder built from
//               4-bit lookahead slices joined by a group lookahead chain.
//               {c_out, f} = a + b + c_in.
// Revision    : 1.0 - initial release
// ============================================================================
module add_tc16_core
    import add_tc_pkg::*;
#(
    parameter int WIDTH = ADD_TC_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic [WIDTH-1:0] f,
    output logic             c_out
);

    localparam int c_NSLICE = WIDTH / 4;

    logic [WIDTH-1:0]    w_g;   // bit generate
    logic [WIDTH-1:0]    w_p;   // bit propagate
    logic [WIDTH-1:0]    w_c;   // carry into each bit
    logic [c_NSLICE-1:0] w_gg;  // slice group generate
    logic [c_NSLICE-1:0] w_gp;  // slice group propagate
    logic [c_NSLICE:0]   w_gc;  // carry into each slice (last = carry out)

    assign w_g = a & b;
    assign w_p = a ^ b;

    for (genvar s = 0; s < c_NSLICE; s++) begin : g_slice
        localparam int c_LSB = 4 * s;

        logic [3:0] w_sg;
        logic [3:0] w_sp;
        logic       w_ci;

        assign w_sg = w_g[c_LSB +: 4];
        assign w_sp = w_p[c_LSB +: 4];
        assign w_ci = w_gc[s];

        // In-slice carries, fully expanded so each depends only on g/p and slice carry-in
        assign w_c[c_LSB + 0] = w_ci;
        assign w_c[c_LSB + 1] = w_sg[0] | (w_sp[0] & w_ci);
        assign w_c[c_LSB + 2] = w_sg[1] | (w_sp[1] & w_sg[0]) | (w_sp[1] & w_sp[0] & w_ci);
        assign w_c[c_LSB + 3] = w_sg[2] | (w_sp[2] & w_sg[1]) | (w_sp[2] & w_sp[1] & w_sg[0])
                              | (w_sp[2] & w_sp[1] & w_sp[0] & w_ci);

        // Group terms let the slice carry chain skip the bit-level ripple
        assign w_gg[s] = w_sg[3] | (w_sp[3] & w_sg[2]) | (w_sp[3] & w_sp[2] & w_sg[1])
                       | (w_sp[3] & w_sp[2] & w_sp[1] & w_sg[0]);
        assign w_gp[s] = &w_sp;
    end

    // Group lookahead: slice carry-ins from group generate/propagate
    always_comb begin
        w_gc[0] = c_in;
        for (int s = 0; s < c_NSLICE; s++) begin
            w_gc[s+1] = w_gg[s] | (w_gp[s] & w_gc[s]);
        end
    end

    assign f     = w_p ^ w_c;
    assign c_out = w_gc[c_NSLICE];

endmodule : add_tc16_core
`default_nettype wire

// File: rtl/add_tc16_pipe.sv
`default_nettype none
// ============================================================================
// Module      : add_tc16_pipe
// Description : Two-stage pipelined two's-complement add/sub unit with
//               valid/ready on both sides. Stage 1 registers A and the
//               conditioned B/carry-in; stage 2 registers the CLA result
//               plus cout/ovf/zero/neg. Also keeps a sticky overflow flag
//               and a wrapping count of delivered results.
//               Build option ADD_TC16_SAT_EN: saturate the sum to the signed
//               min/max on overflow (flags follow the saturated value,
//               cout stays the raw adder carry).
// Revision    : 1.0 - initial release
// ============================================================================
module add_tc16_pipe
    import add_tc_pkg::*;
#(
    parameter int WIDTH = ADD_TC_WIDTH,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero,
    output logic             out_neg,
    input  logic             ovf_clr,
    output logic             ovf_sticky,
    output logic [CNT_W-1:0] op_cnt
);

    localparam int c_MSB = WIDTH - 1;

    logic             w_adv1;
    logic             w_adv2;
    logic             w_deliver;

    logic             r_s1_valid;
    s1_ops_t          r_s1;
    logic             r_s2_valid;
    res_t             r_s2;

    logic [WIDTH-1:0] w_f;
    logic             w_cout;
    logic             w_ovf;
    logic [WIDTH-1:0] w_sum_fin;
    res_t             w_res;

    logic             r_sticky;
    logic [CNT_W-1:0] r_cnt;

    // A stage may advance when it is empty or its successor is advancing
    assign w_adv2    = !r_s2_valid || out_ready;
    assign w_adv1    = !r_s1_valid || w_adv2;
    assign in_ready  = w_adv1;
    assign w_deliver = r_s2_valid && out_ready;

    // Stage 1: capture A and fold subtraction into inverted B plus carry-in
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1       <= '0;
        end else if (w_adv1) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1.a     <= in_a;
                r_s1.b_eff <= (in_op == OP_SUB) ? ~in_b : in_b;
                r_s1.c_in  <= in_op;
            end
        end
    end

    add_tc16_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a     (r_s1.a),
        .b     (r_s1.b_eff),
        .c_in  (r_s1.c_in),
        .f     (w_f),
        .c_out (w_cout)
    );

    // Overflow, optional saturation and flags derived from the final sum
    always_comb begin
        w_ovf = (r_s1.a[c_MSB] == r_s1.b_eff[c_MSB]) && (w_f[c_MSB] != r_s1.a[c_MSB]);
`ifdef ADD_TC16_SAT_EN
        w_sum_fin = w_ovf ? sat_value(r_s1.a[c_MSB]) : w_f;
`else
        w_sum_fin = w_f;
`endif
        w_res      = '0;
        w_res.sum  = w_sum_fin;
        w_res.cout = w_cout;
        w_res.ovf  = w_ovf;
        w_res.zero = (w_sum_fin == '0);
        w_res.neg  = w_sum_fin[c_MSB];
    end

    // Stage 2: result register, held while the consumer stalls
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2       <= '0;
        end else if (w_adv2) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2 <= w_res;
            end
        end
    end

    // Sticky overflow: a delivered overflow wins over a same-cycle clear
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sticky <= 1'b0;
        end else if (w_deliver && r_s2.ovf) begin
            r_sticky <= 1'b1;
        end else if (ovf_clr) begin
            r_sticky <= 1'b0;
        end
    end

    // Delivered-result counter, wraps naturally at 2^CNT_W
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_deliver) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign out_valid  = r_s2_valid;
    assign out_sum    = r_s2.sum;
    assign out_cout   = r_s2.cout;
    assign out_ovf    = r_s2.ovf;
    assign out_zero   = r_s2.zero;
    assign out_neg    = r_s2.neg;
    assign ovf_sticky = r_sticky;
    assign op_cnt     = r_cnt;

endmodule : add_tc16_pipe
`default_nettype wire
